// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring shift-subtract divide.
// One bit per cycle (XLEN+1 cycles to done). Divide-by-zero and signed overflow take a 1-cycle fast path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIN = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [2:0]      op;
  logic [XLEN-1:0] hi, lo, opnd_b;
  logic            neg, fast;

  // Operand conditioning at accept time
  logic            is_div, a_signed, b_signed, sign_a, sign_b, div_zero, div_ovf, neg_in;
  logic [XLEN-1:0] mag_a, mag_b, fast_val;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign sign_a   = a_signed & op_a[XLEN-1];
  assign sign_b   = b_signed & op_b[XLEN-1];
  assign mag_a    = sign_a ? -op_a : op_a;
  assign mag_b    = sign_b ? -op_b : op_b;
  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  // Remainder follows the dividend; quotient and product follow the sign xor.
  assign neg_in   = (is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);

  always_comb begin
    fast_val = '1;
    if (div_zero) fast_val = funct3[1] ? op_a : '1;
    else          fast_val = funct3[1] ? '0 : op_a;
  end

  // One iteration of either algorithm; hi/lo/opnd_b are shared between them
  logic [XLEN:0]   mul_sum, shifted;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_b} : {(XLEN+1){1'b0}});
  assign shifted  = {hi, lo[XLEN-1]};
  assign div_ge   = shifted >= {1'b0, opnd_b};
  assign div_diff = shifted[XLEN-1:0] - opnd_b;

  // Sign correction of the finished magnitude result
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, fin_val;

  assign prod_fix = neg ? -{hi, lo} : {hi, lo};
  assign div_sel  = op[1] ? hi : lo;
  assign div_fix  = neg ? -div_sel : div_sel;

  always_comb begin
    fin_val = lo;
    if (!fast) begin
      if (op[2])                fin_val = div_fix;
      else if (op[1:0] == 2'b00) fin_val = prod_fix[XLEN-1:0];
      else                      fin_val = prod_fix[2*XLEN-1:XLEN];
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      op     <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd_b <= '0;
      neg    <= 1'b0;
      fast   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op     <= funct3;
            neg    <= neg_in;
            fast   <= div_zero | div_ovf;
            count  <= '0;
            hi     <= '0;
            opnd_b <= mag_b;
            lo     <= (div_zero | div_ovf) ? fast_val : mag_a;
            state  <= (div_zero | div_ovf) ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (op[2]) begin
              hi <= div_ge ? div_diff : shifted[XLEN-1:0];
              lo <= {lo[XLEN-2:0], div_ge};
            end else begin
              hi <= mul_sum[XLEN:1];
              lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
            count <= count + 1'b1;
            if (count == LAST) state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          if (!flush) begin
            result <= fin_val;
            done   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit with a start/busy/done handshake, parametrised in data width. It sits beside the single-cycle ALU for the upcoming multi-cycle core. The core stalls while busy=1 and writes back result on the done pulse. Multiplication uses radix-2 shift-add and division uses restoring shift-subtract, one bit per cycle, with sign handling applied at capture and at finish.

Parameters:
XLEN, 32, operand/result width (any value >= 4; counter width clog2(XLEN)+1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; accepted only in IDLE
flush  input  1  synchronous cancel of any in-flight operation
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (multiplicand/dividend)
op_b  input  XLEN  rs2 value (multiplier/divisor)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result valid this cycle
result  output  XLEN  registered result; held until next completion

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, internal accumulators/counter=0.
- States: IDLE, CALC, FIN.
- IDLE: start=1 and flush=0 at edge E0 -> latch funct3, operand magnitudes, sign flags; busy=1.
  - Normal path -> CALC, count=0.
  - Fast path -> FIN directly with precomputed result.
- Fast path triggers:
  - Divide by zero: DIV/DIVU -> all-ones; REM/REMU -> op_a.
  - Signed overflow, DIV/REM with op_a=100..0 and op_b=all-ones: DIV -> op_a; REM -> 0.
- CALC: one iteration per edge, XLEN iterations (E1..E_XLEN); count increments; after the XLEN-th iteration -> FIN.
- FIN: at next edge, result <= sign-corrected value, done=1 for the following cycle, busy=0, state -> IDLE.
- Latency from accept edge to done-visible cycle: XLEN+1 cycles (33 at XLEN=32) on the normal path; 1 cycle on the fast path.
- Multiply: form the 2*XLEN unsigned product of magnitudes, then negate it when the operand signs differ.
  - MUL -> low XLEN bits.
  - MULH/MULHSU/MULHU -> high XLEN bits.
  - Signedness: MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned. MUL low word is sign-agnostic.
- Divide: unsigned restoring division of magnitudes.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - DIVU/REMU use raw values.
- Handshake:
  - start while busy=1 is ignored (no queueing).
  - op_a/op_b/funct3 are sampled only at accept; later changes have no effect.
  - done is a pulse, never held. The cycle with done=1 is in IDLE, so a start in that cycle is accepted (back-to-back).
- flush=1 at any edge with busy=1 -> IDLE, busy=0, no done, result unchanged.
- flush=1 with start=1 in IDLE -> start dropped.
- Async reset mid-operation aborts with no done; the first start after reset release behaves normally.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product); no exceptions are raised.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> result=0xFFFFFFEB. done exactly 33 cycles after the accept edge; busy high for 33 cycles.
- High-word products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Division results:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100%7 -> 2.
  - Each takes 33-cycle latency.
- Corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - Each asserts done 1 cycle after accept.
- Handshake:
  - Second start at cycle 10 of a MUL is ignored, and the first result is unaltered.
  - start in the done cycle is accepted, and its result arrives 33 cycles later.
- Aborts:
  - flush at cycle 12 of DIVU -> busy=0 next cycle, no done, result keeps its previous value.
  - rst pulse mid-CALC -> busy=0, done=0, result=0 immediately (async).
